// File: rtl/register_file_param.sv
// Parametrised dual-read/single-write register file with registered reads and a per-register pending bit.
// Define REGFILE_BYPASS_EN for write-first forwarding on same-cycle same-address read/write; default is read-first.
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  BUSY_R1,
  output logic                  BUSY_R2,
  output logic                  VALID_R,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  input  logic                  RESERVE,
  input  logic [ADDR_WIDTH-1:0] ADDR_RES
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;

  logic [DATA_WIDTH-1:0] data_r1_q, data_r1_d, data_r2_q, data_r2_d;
  logic                  busy_r1_q, busy_r1_d, busy_r2_q, busy_r2_d;
  logic                  valid_r_q, valid_r_d;

  logic                  wr_en, res_en;
  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  rd_busy [2];

  assign rd_addr[0] = ADDR_R1;
  assign rd_addr[1] = ADDR_R2;

  // With a hard-wired zero register, writes and reserves to address 0 are discarded.
  always_comb begin
    wr_en  = WRITE && !((ZERO_REG != 0) && (ADDR_W == '0));
    res_en = RESERVE && !((ZERO_REG != 0) && (ADDR_RES == '0));
  end

  // Reserve is applied after the write so a newer producer keeps the register pending.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_en) begin
      mem_d[ADDR_W]  = DATA_W;
      pend_d[ADDR_W] = 1'b0;
    end
    if (res_en) begin
      pend_d[ADDR_RES] = 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_addr[p]];
      rd_busy[p] = pend_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (ADDR_W == rd_addr[p])) begin
        rd_data[p] = DATA_W;
        rd_busy[p] = 1'b0;
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  // Read outputs hold their last values whenever no read is requested.
  always_comb begin
    data_r1_d = data_r1_q;
    data_r2_d = data_r2_q;
    busy_r1_d = busy_r1_q;
    busy_r2_d = busy_r2_q;
    valid_r_d = READ;
    if (READ) begin
      data_r1_d = rd_data[0];
      data_r2_d = rd_data[1];
      busy_r1_d = rd_busy[0];
      busy_r2_d = rd_busy[1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q    <= '0;
      data_r1_q <= '0;
      data_r2_q <= '0;
      busy_r1_q <= 1'b0;
      busy_r2_q <= 1'b0;
      valid_r_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      pend_q    <= pend_d;
      data_r1_q <= data_r1_d;
      data_r2_q <= data_r2_d;
      busy_r1_q <= busy_r1_d;
      busy_r2_q <= busy_r2_d;
      valid_r_q <= valid_r_d;
    end
  end

  assign DATA_R1 = data_r1_q;
  assign DATA_R2 = data_r2_q;
  assign BUSY_R1 = busy_r1_q;
  assign BUSY_R2 = busy_r2_q;
  assign VALID_R = valid_r_q;

endmodule

// File: tb/tb_register_file_param.sv
// Directed scoreboard bench for register_file_param: default 32x32 zero-reg instance plus a 16-bit x 8 instance without zero reg.
module tb_register_file_param;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        READ = 1'b0, WRITE = 1'b0, RESERVE = 1'b0;
  logic [4:0]  ADDR_R1 = '0, ADDR_R2 = '0, ADDR_W = '0, ADDR_RES = '0;
  logic [31:0] DATA_W = '0;
  logic [31:0] DATA_R1, DATA_R2;
  logic        BUSY_R1, BUSY_R2, VALID_R;

  logic        s_read = 1'b0, s_write = 1'b0, s_reserve = 1'b0;
  logic [2:0]  s_addr_r1 = '0, s_addr_r2 = '0, s_addr_w = '0, s_addr_res = '0;
  logic [15:0] s_data_w = '0;
  logic [15:0] s_data_r1, s_data_r2;
  logic        s_busy_r1, s_busy_r2, s_valid_r;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  register_file_param dut (
    .CLK(CLK), .RST(RST), .READ(READ),
    .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(DATA_R1), .DATA_R2(DATA_R2),
    .BUSY_R1(BUSY_R1), .BUSY_R2(BUSY_R2), .VALID_R(VALID_R),
    .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RESERVE(RESERVE), .ADDR_RES(ADDR_RES)
  );

  register_file_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0)) dut_s (
    .CLK(CLK), .RST(RST), .READ(s_read),
    .ADDR_R1(s_addr_r1), .ADDR_R2(s_addr_r2),
    .DATA_R1(s_data_r1), .DATA_R2(s_data_r2),
    .BUSY_R1(s_busy_r1), .BUSY_R2(s_busy_r2), .VALID_R(s_valid_r),
    .WRITE(s_write), .ADDR_W(s_addr_w), .DATA_W(s_data_w),
    .RESERVE(s_reserve), .ADDR_RES(s_addr_res)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WRITE  = 1'b1;
    ADDR_W = a;
    DATA_W = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    RESERVE  = 1'b1;
    ADDR_RES = a;
  endtask

  task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] d1, input logic [31:0] d2, input logic b1, input logic b2);
    exp_t e;
    READ    = 1'b1;
    ADDR_R1 = a1;
    ADDR_R2 = a2;
    e.tag = tag; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2;
    sb.push_back(e);
  endtask

  // One clock: sample #1 after the edge, compare VALID_R and any expected read, then idle the inputs.
  task automatic tick();
    exp_t e;
    logic issued;
    issued = READ && !RST;
    @(posedge CLK);
    #1;
    check("valid_r", {31'b0, VALID_R}, {31'b0, issued});
    if (issued) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_d1"}, DATA_R1, e.d1);
        check({e.tag, "_d2"}, DATA_R2, e.d2);
        check({e.tag, "_b1"}, {31'b0, BUSY_R1}, {31'b0, e.b1});
        check({e.tag, "_b2"}, {31'b0, BUSY_R2}, {31'b0, e.b2});
      end
    end
    READ = 1'b0; WRITE = 1'b0; RESERVE = 1'b0; RST = 1'b0;
    s_read = 1'b0; s_write = 1'b0; s_reserve = 1'b0;
  endtask

  initial begin
    $display("[TB] start, bypass=%0d", BYP);

    RST = 1'b1;
    tick();
    check("rst_d1", DATA_R1, 32'h0);
    check("rst_b1", {31'b0, BUSY_R1}, 32'h0);

    wr(5'd5, 32'hDEADBEEF);
    tick();
    RST = 1'b1; READ = 1'b1; ADDR_R1 = 5'd5; ADDR_R2 = 5'd5;
    tick();
    rd("after_rst", 5'd5, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    wr(5'd7, 32'h12345678);
    tick();
    wr(5'd31, 32'hCAFEF00D);
    tick();
    rd("basic", 5'd7, 5'd31, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0);
    tick();
    tick();
    check("hold_d1", DATA_R1, 32'h12345678);
    check("hold_d2", DATA_R2, 32'hCAFEF00D);

    wr(5'd0, 32'hFFFFFFFF);
    rsv(5'd0);
    tick();
    rd("zero", 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    wr(5'd9, 32'h11);
    tick();
    wr(5'd9, 32'h22);
    rd("bypass", 5'd9, 5'd7, BYP ? 32'h22 : 32'h11, 32'h12345678, 1'b0, 1'b0);
    tick();
    rd("bypass_next", 5'd9, 5'd9, 32'h22, 32'h22, 1'b0, 1'b0);
    tick();
    wr(5'd9, 32'h33);
    rsv(5'd9);
    rd("bypass_rsv", 5'd9, 5'd9, BYP ? 32'h33 : 32'h22, BYP ? 32'h33 : 32'h22, 1'b0, 1'b0);
    tick();
    rd("bypass_rsv_next", 5'd9, 5'd9, 32'h33, 32'h33, 1'b1, 1'b1);
    tick();

    rsv(5'd12);
    tick();
    rd("rsv12", 5'd12, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    rsv(5'd13);
    rd("rsv13_same", 5'd13, 5'd13, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rd("rsv13_next", 5'd13, 5'd12, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    wr(5'd12, 32'h5);
    tick();
    rd("wr12", 5'd12, 5'd13, 32'h5, 32'h0, 1'b0, 1'b1);
    tick();
    wr(5'd12, 32'h6);
    rsv(5'd12);
    tick();
    rd("wr_rsv12", 5'd12, 5'd12, 32'h6, 32'h6, 1'b1, 1'b1);
    tick();

    rd("b2b_1", 5'd7, 5'd31, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0);
    tick();
    rd("b2b_2", 5'd31, 5'd7, 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b0);
    tick();
    rd("b2b_3", 5'd9, 5'd12, 32'h33, 32'h6, 1'b1, 1'b1);
    tick();

    s_write = 1'b1; s_addr_w = 3'd7; s_data_w = 16'hA5A5;
    tick();
    s_write = 1'b1; s_addr_w = 3'd0; s_data_w = 16'h1234;
    s_reserve = 1'b1; s_addr_res = 3'd3;
    tick();
    s_read = 1'b1; s_addr_r1 = 3'd7; s_addr_r2 = 3'd6;
    tick();
    check("s_valid", {31'b0, s_valid_r}, 32'h1);
    check("s_d1_r7", {16'b0, s_data_r1}, 32'h0000A5A5);
    check("s_d2_r6", {16'b0, s_data_r2}, 32'h0);
    s_read = 1'b1; s_addr_r1 = 3'd0; s_addr_r2 = 3'd3;
    tick();
    check("s_d1_r0", {16'b0, s_data_r1}, 32'h00001234);
    check("s_b1_r0", {31'b0, s_busy_r1}, 32'h0);
    check("s_b2_r3", {31'b0, s_busy_r2}, 32'h1);
    tick();
    check("s_valid_low", {31'b0, s_valid_r}, 32'h0);

    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
